// File: rtl/jam_cost_server_pkg.sv
// Shared types and constants for the jam_cost_server cost-table responder.
package jam_cost_server_pkg;

    localparam int N           = 8;
    localparam int COST_W      = 7;
    localparam int SUM_W       = 10;
    localparam int TABLE_DEPTH = N * N;
    localparam int IDX_W       = 3;
    localparam int LIDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// 64x7 cost storage: one write port for the host load, one registered read
// port for engine lookups. The read register returns 0 whenever the read
// enable is low, so Cost stays quiet outside the serving states.
module jam_cost_mem
    import jam_cost_server_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [LIDX_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic              re,
    input  logic [LIDX_W-1:0] raddr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] mem [TABLE_DEPTH];

    // Table write; storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read, forced to zero when the read port is disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table responder for the job-assignment engine: serial table load,
// 1-cycle cost lookups, and capture of the engine's final result.
// Optional feature macro: JAM_COST_SERVER_LOOKUP_CNT_EN adds lookup_cnt,
// a saturating count of SERVE cycles whose {W,J} changed.
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// LOAD  | accepting 64 row-major entries from the host
// SERVE | table valid, answering lookups, waiting for jam_valid
// DONE  | result captured, lookups continue, load_start restarts a load
module jam_cost_server
    import jam_cost_server_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_ready,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              jam_valid,
    input  logic [SUM_W-1:0]  jam_min_cost,
    input  logic [3:0]        jam_match_count,
    output logic              done,
    output logic [SUM_W-1:0]  result_min_cost,
    output logic [3:0]        result_match_count
`ifdef JAM_COST_SERVER_LOOKUP_CNT_EN
    ,
    output logic [15:0]       lookup_cnt
`endif
);

    state_t            state;
    logic [LIDX_W-1:0] load_idx;
    logic              accept;
    logic              mem_re;
    logic              restart;

    // load_ready is a registered copy of "state is LOAD", so it gates writes directly.
    assign accept  = load_valid & load_ready;
    assign restart = (state == DONE) && load_start;
    // Drop the read port on the edge that leaves DONE so Cost is already 0 in LOAD.
    assign mem_re  = (state == SERVE) || ((state == DONE) && !load_start);

    jam_cost_mem u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (accept),
        .waddr (load_idx),
        .wdata (load_data),
        .re    (mem_re),
        .raddr ({W, J}),
        .rdata (Cost)
    );

    // Sequencing FSM with registered handshake/status outputs and result capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state              <= IDLE;
            load_ready         <= 1'b0;
            table_ready        <= 1'b0;
            done               <= 1'b0;
            load_idx           <= '0;
            result_min_cost    <= '0;
            result_match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        load_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_idx <= load_idx + LIDX_W'(1);
                        if (load_idx == LIDX_W'(TABLE_DEPTH - 1)) begin
                            state       <= SERVE;
                            load_ready  <= 1'b0;
                            table_ready <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (jam_valid) begin
                        state              <= DONE;
                        done               <= 1'b1;
                        result_min_cost    <= jam_min_cost;
                        result_match_count <= jam_match_count;
                    end
                end
                DONE: begin
                    // load_start takes priority; jam_valid is never looked at here.
                    if (load_start) begin
                        state       <= LOAD;
                        done        <= 1'b0;
                        table_ready <= 1'b0;
                        load_ready  <= 1'b1;
                        load_idx    <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    load_ready  <= 1'b0;
                    table_ready <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

`ifdef JAM_COST_SERVER_LOOKUP_CNT_EN
    logic [LIDX_W-1:0] prev_key;

    // Count address changes while serving; cleared when a load begins, frozen otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookup_cnt <= '0;
            prev_key   <= '0;
        end else begin
            prev_key <= {W, J};
            if (((state == IDLE) && load_start) || restart) begin
                lookup_cnt <= '0;
            end else if ((state == SERVE) && ({W, J} != prev_key) &&
                         (lookup_cnt != 16'hFFFF)) begin
                lookup_cnt <= lookup_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: lookups push expected costs from a
// flat array model of the table; a monitor pops and compares one cycle later.
module tb_jam_cost_server;
    import jam_cost_server_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [COST_W-1:0] load_data = '0;
    logic              load_ready;
    logic              table_ready;
    logic [IDX_W-1:0]  W = '0;
    logic [IDX_W-1:0]  J = '0;
    logic [COST_W-1:0] Cost;
    logic              jam_valid = 1'b0;
    logic [SUM_W-1:0]  jam_min_cost = '0;
    logic [3:0]        jam_match_count = '0;
    logic              done;
    logic [SUM_W-1:0]  result_min_cost;
    logic [3:0]        result_match_count;
`ifdef JAM_COST_SERVER_LOOKUP_CNT_EN
    logic [15:0]       lookup_cnt;
`endif

    jam_cost_server dut (
        .CLK                (CLK),
        .RST                (RST),
        .load_start         (load_start),
        .load_valid         (load_valid),
        .load_data          (load_data),
        .load_ready         (load_ready),
        .table_ready        (table_ready),
        .W                  (W),
        .J                  (J),
        .Cost               (Cost),
        .jam_valid          (jam_valid),
        .jam_min_cost       (jam_min_cost),
        .jam_match_count    (jam_match_count),
        .done               (done),
        .result_min_cost    (result_min_cost),
        .result_match_count (result_match_count)
`ifdef JAM_COST_SERVER_LOOKUP_CNT_EN
        ,
        .lookup_cnt         (lookup_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int model   [64];
    int ld_data [64];
    int exp_q [$];
    logic lk_req  = 1'b0;
    logic lk_pend = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A lookup driven before a posedge is answered at the following negedge.
    always @(posedge CLK) lk_pend <= lk_req;

    always @(negedge CLK) begin
        if (lk_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cost_underflow: got Cost=%0d with no expectation queued", Cost);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(Cost) != e) begin
                    errors++;
                    $display("FAIL cost W=%0d J=%0d: got %0d expected %0d", W, J, Cost, e);
                end
            end
        end
    end

    task automatic lookup(input int w, input int j, input int exp);
        @(negedge CLK);
        W = IDX_W'(w);
        J = IDX_W'(j);
        lk_req = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic lk_end();
        @(negedge CLK);
        lk_req = 1'b0;
    endtask

    task automatic fill_mult3();
        for (int k = 0; k < 64; k++) ld_data[k] = (k * 3) % 128;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 64; k++) ld_data[k] = int'($urandom_range(0, 127));
    endtask

    // Drives ld_data into the DUT; stops early after abort_at accepts.
    task automatic do_load(input bit issue_start, input bit toggle, input int abort_at,
                           input int exp_ready, input string tag);
        int  k = 0;
        int  c = 0;
        int  ready_cnt = 0;
        bit  v;
        bit  lr;
        if (issue_start) begin
            @(negedge CLK);
            load_start = 1'b1;
        end
        while (c < 400) begin
            @(negedge CLK);
            load_start = 1'b0;
            if (table_ready) break;
            lr = load_ready;
            if (lr) ready_cnt++;
            if (k == abort_at) break;
            v = !toggle || (c % 2 == 0);
            load_valid = v;
            load_data  = COST_W'(ld_data[k]);
            if (lr && v) k++;
            c++;
        end
        load_valid = 1'b0;
        if (abort_at < 64) return;
        chk({tag, "_table_ready"}, int'(table_ready), 1);
        chk({tag, "_ready_after"}, int'(load_ready), 0);
        chk({tag, "_accepts"}, k, 64);
        chk({tag, "_ready_cycles"}, ready_cnt, exp_ready);
        for (int i = 0; i < 64; i++) model[i] = ld_data[i];
    endtask

    task automatic jam(input int mc, input int cnt);
        @(negedge CLK);
        jam_valid       = 1'b1;
        jam_min_cost    = SUM_W'(mc);
        jam_match_count = 4'(cnt);
        @(negedge CLK);
        jam_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("rst_load_ready", int'(load_ready), 0);
        chk("rst_table_ready", int'(table_ready), 0);
        chk("rst_cost", int'(Cost), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result_min", int'(result_min_cost), 0);
        chk("rst_result_cnt", int'(result_match_count), 0);

        // Load k*3 with valid held high
        fill_mult3();
        do_load(1'b1, 1'b0, 64, 64, "load1");
        lookup(2, 5, 63);
        lookup(7, 7, 61);
        lookup(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            int w, j;
            w = int'($urandom_range(0, 7));
            j = int'($urandom_range(0, 7));
            lookup(w, j, model[w * 8 + j]);
        end
        lk_end();

        // Result capture, then jam_valid ignored in DONE
        chk("serve_done", int'(done), 0);
        jam(328, 2);
        chk("cap_done", int'(done), 1);
        chk("cap_min", int'(result_min_cost), 328);
        chk("cap_cnt", int'(result_match_count), 2);
        jam(500, 5);
        chk("hold_done", int'(done), 1);
        chk("hold_min", int'(result_min_cost), 328);
        chk("hold_cnt", int'(result_match_count), 2);
        chk("done_table_ready", int'(table_ready), 1);
        for (int i = 0; i < 6; i++) begin
            int w, j;
            w = int'($urandom_range(0, 7));
            j = int'($urandom_range(0, 7));
            lookup(w, j, model[w * 8 + j]);
        end
        lk_end();

        // load_start and jam_valid together in DONE
        @(negedge CLK);
        load_start      = 1'b1;
        jam_valid       = 1'b1;
        jam_min_cost    = 10'd500;
        jam_match_count = 4'd5;
        @(negedge CLK);
        load_start = 1'b0;
        jam_valid  = 1'b0;
        chk("reload_ready", int'(load_ready), 1);
        chk("reload_done", int'(done), 0);
        chk("reload_table_ready", int'(table_ready), 0);
        chk("reload_min", int'(result_min_cost), 328);
        chk("reload_cnt", int'(result_match_count), 2);
        chk("reload_cost", int'(Cost), 0);
        fill_rand();
        do_load(1'b0, 1'b0, 64, 64, "load2");
        for (int i = 0; i < 20; i++) begin
            int w, j;
            w = int'($urandom_range(0, 7));
            j = int'($urandom_range(0, 7));
            lookup(w, j, model[w * 8 + j]);
        end
        lk_end();

        // Reset after 20 accepted entries
        fill_mult3();
        do_load(1'b1, 1'b1, 20, 0, "abort");
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_load_ready", int'(load_ready), 0);
        chk("abort_table_ready", int'(table_ready), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cost", int'(Cost), 0);
        RST = 1'b0;
        W = '0;
        J = '0;
        repeat (2) @(negedge CLK);
        chk("abort_idle_ready", int'(load_ready), 0);

        // Full reload with valid toggling, then complete readback
        do_load(1'b1, 1'b1, 64, 127, "load3");
`ifdef JAM_COST_SERVER_LOOKUP_CNT_EN
        for (int i = 1; i < 8; i++) lookup(i, i, model[i * 8 + i]);
        lookup(0, 1, model[1]);
        repeat (3) lookup(0, 1, model[1]);
        lk_end();
        chk("lookup_cnt", int'(lookup_cnt), 8);
`endif
        lookup(1, 2, 30);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                lookup(w, j, ((w * 8 + j) * 3) % 128);
            end
        end
        lk_end();
        repeat (2) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
